// File: rtl/ysyx_23060025_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060025_csr_ctrl
// Description : CSR instruction controller. Sequences CSRRW/CSRRS/CSRRC
//               read-modify-write accesses to an external CSR file, ECALL
//               trap entry (mepc/mcause update, redirect to mtvec) and MRET
//               return (redirect to mepc). Results are handed downstream
//               through a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060025_csr_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    // request side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] src_i,
    input  logic [DATA_WIDTH-1:0] pc_i,

    // CSR file access
    output logic [11:0]           csr_addr_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i,
    output logic                  csr_we_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,

    // trap entry / return
    output logic                  csr_trap_we_o,
    output logic [DATA_WIDTH-1:0] csr_mepc_o,
    output logic [DATA_WIDTH-1:0] csr_mcause_o,
    input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic [DATA_WIDTH-1:0] csr_mepc_i,

    // response side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  redirect_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o
);

    // ------------------------------------------------------------------------
    // Operation encodings and constants
    // ------------------------------------------------------------------------
    localparam logic [2:0]            C_OP_CSRRW = 3'b001;
    localparam logic [2:0]            C_OP_CSRRS = 3'b010;
    localparam logic [2:0]            C_OP_CSRRC = 3'b011;
    localparam logic [2:0]            C_OP_ECALL = 3'b100;
    localparam logic [2:0]            C_OP_MRET  = 3'b101;
    // Environment call from M-mode
    localparam logic [DATA_WIDTH-1:0] C_MCAUSE_ECALL = DATA_WIDTH'(11);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_TRAP  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                  r_state;
    // Goes high on the first clock edge after reset release; keeps in_ready
    // low while reset is held even though the FSM already sits in IDLE.
    logic                    r_live;
    logic [2:0]              r_op;
    logic [11:0]             r_addr;
    logic [DATA_WIDTH-1:0]   r_src;
    logic [DATA_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_redirect;
    logic [DATA_WIDTH-1:0]   r_redirect_pc;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_trap_we;
    logic [DATA_WIDTH-1:0]   r_mepc;
    logic [DATA_WIDTH-1:0]   r_mcause;

    logic                    w_accept;
    logic                    w_resp_done;
    logic                    w_skip_write;
    logic [DATA_WIDTH-1:0]   w_wdata;

    assign in_ready      = r_live && (r_state == S_IDLE);
    assign out_valid     = (r_state == S_RESP);
    assign w_accept      = in_valid && in_ready;
    assign w_resp_done   = out_valid && out_ready;

    assign csr_addr_o    = r_addr;
    assign csr_we_o      = r_we;
    assign csr_wdata_o   = r_wdata;
    assign csr_trap_we_o = r_trap_we;
    assign csr_mepc_o    = r_mepc;
    assign csr_mcause_o  = r_mcause;
    assign rd_data_o     = r_rd_data;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;

    // Set/clear forms with a zero mask would leave the CSR unchanged, so the
    // write (and its side effects in the CSR file) is skipped entirely.
    assign w_skip_write = ((r_op == C_OP_CSRRS) || (r_op == C_OP_CSRRC)) &&
                          (r_src == '0);

    // New CSR value computed from the value read back in READ
    always_comb begin
        w_wdata = r_src;
        case (r_op)
            C_OP_CSRRS: w_wdata = csr_rdata_i | r_src;
            C_OP_CSRRC: w_wdata = csr_rdata_i & ~r_src;
            default:    w_wdata = r_src;
        endcase
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_live        <= 1'b0;
            r_op          <= 3'b000;
            r_addr        <= 12'h000;
            r_src         <= '0;
            r_pc          <= '0;
            r_rd_data     <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_trap_we     <= 1'b0;
            r_mepc        <= '0;
            r_mcause      <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op          <= op_i;
                        r_addr        <= csr_addr_i;
                        r_src         <= src_i;
                        r_pc          <= pc_i;
                        r_rd_data     <= '0;
                        r_redirect    <= 1'b0;
                        r_redirect_pc <= '0;
                        case (op_i)
                            C_OP_CSRRW, C_OP_CSRRS, C_OP_CSRRC: begin
                                r_state <= S_READ;
                            end
                            C_OP_ECALL: begin
                                r_trap_we <= 1'b1;
                                r_mepc    <= pc_i;
                                r_mcause  <= C_MCAUSE_ECALL;
                                r_state   <= S_TRAP;
                            end
                            C_OP_MRET: begin
                                r_redirect    <= 1'b1;
                                r_redirect_pc <= csr_mepc_i;
                                r_state       <= S_RESP;
                            end
                            default: begin
                                r_state <= S_RESP;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    r_rd_data <= csr_rdata_i;
                    if (w_skip_write) begin
                        r_state <= S_RESP;
                    end else begin
                        r_we    <= 1'b1;
                        r_wdata <= w_wdata;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_state <= S_RESP;
                end
                S_TRAP: begin
                    r_trap_we     <= 1'b0;
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= csr_mtvec_i;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_redirect <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_we      <= 1'b0;
                    r_trap_we <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060025_csr_ctrl.md
YSYX_23060025_CSR_CTRL -- requirements
Module: ysyx_23060025_csr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  upstream request valid.
REQ-005 SHALL have port in_ready  out  1  controller can accept a request.
REQ-006 SHALL have port op_i  in  3  operation: 001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 MRET; other codes are NOP.
REQ-007 SHALL have ports csr_addr_i (in, 12, target CSR), src_i (in, DATA_WIDTH, rs1/zimm operand) and pc_i (in, DATA_WIDTH, instruction PC).
REQ-008 SHALL have ports csr_addr_o (out, 12), csr_rdata_i (in, DATA_WIDTH), csr_we_o (out, 1, write strobe) and csr_wdata_o (out, DATA_WIDTH) toward the CSR file.
REQ-009 SHALL have ports csr_trap_we_o (out, 1), csr_mepc_o (out, DATA_WIDTH), csr_mcause_o (out, DATA_WIDTH), csr_mtvec_i (in, DATA_WIDTH) and csr_mepc_i (in, DATA_WIDTH) for trap entry and return.
REQ-010 SHALL have ports out_valid (out, 1), out_ready (in, 1), rd_data_o (out, DATA_WIDTH, old CSR value), redirect_o (out, 1, PC redirect) and redirect_pc_o (out, DATA_WIDTH).

Function
REQ-011 SHALL implement FSM states IDLE, READ, WRITE, TRAP, RESP.
REQ-012 in_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with in_valid & in_ready.
REQ-013 On acceptance, op_i, csr_addr_i, src_i and pc_i SHALL be latched; later input changes SHALL have no effect.
REQ-014 Accepted op transitions SHALL be: CSRRW/S/C -> READ; ECALL -> TRAP; MRET -> RESP; NOP -> RESP.
REQ-015 csr_addr_o SHALL equal the latched address in all states.
REQ-016 In READ, csr_rdata_i SHALL be captured into rd_data_o.
REQ-017 Write data SHALL be: CSRRW = src; CSRRS = old | src; CSRRC = old & ~src.
REQ-018 READ -> WRITE, except CSRRS/CSRRC with src == 0, which go READ -> RESP and never assert csr_we_o.
REQ-019 In WRITE, csr_we_o SHALL be 1 for exactly one cycle with csr_wdata_o valid; then the FSM goes to RESP.
REQ-020 In TRAP, csr_trap_we_o SHALL be 1 for exactly one cycle, with csr_mepc_o = latched pc and csr_mcause_o = 11.
REQ-021 In TRAP, redirect_pc_o SHALL latch csr_mtvec_i; then the FSM goes to RESP.
REQ-022 For MRET, redirect_pc_o SHALL latch csr_mepc_i in the accept cycle.
REQ-023 redirect_o SHALL be 1 in RESP only for ECALL and MRET.
REQ-024 rd_data_o SHALL be 0 for ECALL, MRET and NOP.
REQ-025 out_valid SHALL be 1 only in RESP.
REQ-026 rd_data_o, redirect_o and redirect_pc_o SHALL be held stable while out_valid & ~out_ready.
REQ-027 RESP -> IDLE on out_valid & out_ready; no new request is accepted in that same cycle.
REQ-028 Latency from accept cycle N to out_valid SHALL be:
- CSRRW: N+3
- CSRRS/CSRRC with write: N+3
- CSRRS/CSRRC without write: N+2
- ECALL: N+2
- MRET and NOP: N+1
REQ-029 csr_we_o and csr_trap_we_o SHALL never both be 1, and SHALL never be 1 outside WRITE and TRAP respectively.

Reset
REQ-030 When reset = 0, the FSM SHALL enter IDLE immediately, independent of clock.
REQ-031 During reset, these outputs SHALL be 0: out_valid, csr_we_o, csr_trap_we_o, redirect_o, rd_data_o, redirect_pc_o, csr_wdata_o, csr_mepc_o, csr_mcause_o, csr_addr_o.
REQ-032 in_ready SHALL be 0 while reset is asserted.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no further CSR strobe; after release, in_ready = 1 on the first clock edge.

Verification
REQ-034 CSRRW, addr 0x305, src 0x80000100, csr_rdata_i 0x0 -> one csr_we_o pulse with wdata 0x80000100, then out_valid at N+3 with rd_data_o 0x0 and redirect_o 0.
REQ-035 CSRRS, addr 0x300, src 0x8, old 0x1800 -> wdata 0x1808, then rd_data_o 0x1800; CSRRC with src 0x0 -> no csr_we_o and out_valid at N+2.
REQ-036 ECALL, pc 0x80000040, csr_mtvec_i 0x80000200 -> one csr_trap_we_o pulse with mepc 0x80000040 and mcause 11, then redirect_o 1 with redirect_pc_o 0x80000200 at N+2.
REQ-037 MRET, csr_mepc_i 0x80000044 -> out_valid at N+1 with redirect_pc_o 0x80000044; out_ready held 0 for 5 cycles -> all outputs stable and in_ready 0.
REQ-038 Reset pulsed low during WRITE -> csr_we_o drops asynchronously, FSM returns to IDLE, and the next CSRRW completes normally.
